// File: rtl/dmem_responder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : dmem_responder_if
// Purpose  : Pipe2 load/store request and data-memory response bundle.
//            master = pipeline side, slave = memory responder side.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ren;
   logic        req_wen;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_wmask;
   logic        stage_advance;
   logic        mem_finish;
   logic [63:0] rdata;
   logic        addr_err;
   logic        busy;

   modport master (
      output req_valid, req_ren, req_wen, req_addr, req_wdata, req_wmask,
      output stage_advance,
      input  mem_finish, rdata, addr_err, busy
   );

   modport slave (
      input  req_valid, req_ren, req_wen, req_addr, req_wdata, req_wmask,
      input  stage_advance,
      output mem_finish, rdata, addr_err, busy
   );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : dmem_responder
// Purpose  : Fixed-latency data-memory responder for pipe2. Accepts the
//            stage's load/store request, performs it on an internal
//            64-bit-word RAM and holds mem_finish/rdata until hand-off.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module dmem_responder #(
   parameter int          DEPTH   = 1024,
   parameter logic [63:0] BASE    = 64'h8000_0000,
   parameter int          LATENCY = 2
) (
   input  wire logic          clk,
   input  wire logic          rst,
   dmem_responder_if.slave    bus
);

   localparam int          c_IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]  c_CNT_LOAD = 4'(LATENCY - 1);
   localparam logic [60:0] c_DEPTH_W  = 61'(DEPTH);
   localparam bit          c_ONE_CYC  = (LATENCY == 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t        state_q,    state_d;
   logic [3:0]    cnt_q,      cnt_d;
   logic [63:0]   addr_q,     addr_d;
   logic [63:0]   wdata_q,    wdata_d;
   logic [7:0]    wmask_q,    wmask_d;
   logic          ren_q,      ren_d;
   logic          wen_q,      wen_d;
   logic [63:0]   rdata_q,    rdata_d;
   logic          addr_err_q, addr_err_d;

   logic [63:0]   ram [DEPTH];

   logic               accept;
   logic               exec;
   logic [63:0]        acc_addr;
   logic [63:0]        acc_wdata;
   logic [7:0]         acc_wmask;
   logic               acc_ren;
   logic               acc_wen;
   logic [63:0]        off;
   logic               in_range;
   logic [c_IDX_W-1:0] idx;
   logic               unused_off_lsbs;

   // Operand select: with single-cycle latency the access executes on the
   // acceptance edge, so the live request is used instead of the latches.
   always_comb begin
      accept    = (state_q == ST_IDLE) && bus.req_valid && (bus.req_ren || bus.req_wen);
      exec      = (accept && c_ONE_CYC) || ((state_q == ST_WAIT) && (cnt_q == 4'd1));
      acc_addr  = (state_q == ST_IDLE) ? bus.req_addr  : addr_q;
      acc_wdata = (state_q == ST_IDLE) ? bus.req_wdata : wdata_q;
      acc_wmask = (state_q == ST_IDLE) ? bus.req_wmask : wmask_q;
      acc_ren   = (state_q == ST_IDLE) ? bus.req_ren   : ren_q;
      acc_wen   = (state_q == ST_IDLE) ? bus.req_wen   : wen_q;
      off       = acc_addr - BASE;
      in_range  = (acc_addr >= BASE) && (off[63:3] < c_DEPTH_W);
      idx       = off[c_IDX_W+2:3];
      unused_off_lsbs = ^off[2:0];
   end

   // Next-state and next-output computation for the access FSM.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wmask_d    = wmask_q;
      ren_d      = ren_q;
      wen_d      = wen_q;
      rdata_d    = rdata_q;
      addr_err_d = addr_err_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               wmask_d = bus.req_wmask;
               ren_d   = bus.req_ren;
               wen_d   = bus.req_wen;
               cnt_d   = c_CNT_LOAD;
               state_d = c_ONE_CYC ? ST_DONE : ST_WAIT;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.stage_advance) begin
               state_d    = ST_IDLE;
               addr_err_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // The read samples the pre-store word, giving read-before-write.
      if (exec) begin
         if (!in_range) begin
            rdata_d    = 64'd0;
            addr_err_d = 1'b1;
         end else if (acc_ren) begin
            rdata_d = ram[idx];
         end
      end
   end

   // Register FSM state, latched request and response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 4'd0;
         addr_q     <= 64'd0;
         wdata_q    <= 64'd0;
         wmask_q    <= 8'd0;
         ren_q      <= 1'b0;
         wen_q      <= 1'b0;
         rdata_q    <= 64'd0;
         addr_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wmask_q    <= wmask_d;
         ren_q      <= ren_d;
         wen_q      <= wen_d;
         rdata_q    <= rdata_d;
         addr_err_q <= addr_err_d;
      end
   end

   // Byte-masked store, committed only on the single DONE-entry edge.
   always_ff @(posedge clk) begin
      if (!rst && exec && in_range && acc_wen) begin
         for (int i = 0; i < 8; i++) begin
            if (acc_wmask[i]) begin
               ram[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
         end
      end
   end

   // Non-memory instructions finish combinationally so they never stall.
   assign bus.mem_finish = (state_q == ST_DONE) ||
                           ((state_q == ST_IDLE) && bus.req_valid && !bus.req_ren && !bus.req_wen);
   assign bus.rdata      = rdata_q;
   assign bus.addr_err   = addr_err_q;
   assign bus.busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire
